// File: rtl/exec_fpu_pkg.sv
// Shared constants, packed execute-instruction layout and FSM encoding for the EXEC_FPU slot.
package exec_fpu_pkg;
  localparam int D_SIZE      = 32;
  localparam int REG_A_SIZE  = 3;
  localparam int OPCODE_SIZE = 7;
  localparam int OP0_SIZE    = REG_A_SIZE + 1;
  localparam int I_EXEC_SIZE = OPCODE_SIZE + OP0_SIZE + 2 * D_SIZE;

  localparam logic [OPCODE_SIZE-1:0] NOP  = 7'h00;
  localparam logic [OPCODE_SIZE-1:0] ADDF = 7'h21;
  localparam logic [OPCODE_SIZE-1:0] SUBF = 7'h22;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;

  localparam logic [I_EXEC_SIZE-1:0] NOP_INSTR = {NOP, {(I_EXEC_SIZE - OPCODE_SIZE){1'b0}}};

  typedef struct packed {
    logic [OPCODE_SIZE-1:0] opcode;
    logic [OP0_SIZE-1:0]    op0;
    logic [D_SIZE-1:0]      dat1;
    logic [D_SIZE-1:0]      dat2;
  } execInstr_t;

  typedef enum logic [2:0] {
    FPU_IDLE   = 3'd0,
    FPU_ALIGN  = 3'd1,
    FPU_ADDSUB = 3'd2,
    FPU_NORM   = 3'd3,
    FPU_ROUND  = 3'd4,
    FPU_DONE   = 3'd5
  } fpuState_e;

  function automatic logic isFpOpcode(input logic [OPCODE_SIZE-1:0] opc);
    return (opc == ADDF) || (opc == SUBF);
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over a 27-bit mantissa; an all-zero input reports 27.
module fp_lzc (
  input  logic [26:0] value_i,
  output logic [4:0]  count_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i <= 26; i++) begin
      if (value_i[i]) begin
        count_o = 5'(26 - i);
      end
    end
  end

endmodule

// File: rtl/exec_fpu.sv
// Multi-cycle binary32 adder/subtractor: ALIGN, ADDSUB, NORM and ROUND each take one cycle,
// then the result is held in DONE until write_back consumes it.
module exec_fpu
  import exec_fpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [I_EXEC_SIZE-1:0] instruction_in,
  input  logic                   backpressure_write_back,
  output logic [I_EXEC_SIZE-1:0] instruction_out_floating_point,
  output logic                   backpressure_exec_fpu
);

  fpuState_e              state_q, state_d;
  logic [OPCODE_SIZE-1:0] opcode_q, opcode_d;
  logic [OP0_SIZE-1:0]    op0_q, op0_d;
  logic [31:0]            opA_q, opA_d, opB_q, opB_d;
  logic                   sign_q, sign_d;
  logic                   effSub_q, effSub_d;
  logic [9:0]             exp_q, exp_d;
  logic [26:0]            manX_q, manX_d, manY_q, manY_d;
  logic [27:0]            sum_q, sum_d;
  logic                   special_q, special_d;
  logic [31:0]            specVal_q, specVal_d;
  logic [I_EXEC_SIZE-1:0] out_q, out_d;

  execInstr_t  instrIn;
  logic [4:0]  lzCount;

  logic        isSub, signA, signB, zeroA, zeroB, nanA, nanB, infA, infB, swap, bigSign;
  logic [7:0]  expA, expB, expDiff;
  logic [30:0] magA, magB, bigMag, smallMag;
  logic [4:0]  shamt;
  logic [26:0] manBig, manSmall, shifted, lostMask, manAligned;
  logic        alignSpecial;
  logic [31:0] alignSpecVal;

  logic        roundUp;
  logic [24:0] mantR;
  logic [9:0]  expR;
  logic [31:0] roundResult;

  assign instrIn = instruction_in;

  fp_lzc u_lzc (
    .value_i (sum_q[26:0]),
    .count_o (lzCount)
  );

  // Unpack, flush subnormals, order by magnitude and pre-shift the smaller mantissa with sticky.
  always_comb begin
    isSub    = (opcode_q == SUBF);
    signA    = opA_q[31];
    signB    = opB_q[31] ^ isSub;
    expA     = opA_q[FP_MAN_W +: FP_EXP_W];
    expB     = opB_q[FP_MAN_W +: FP_EXP_W];
    zeroA    = (expA == 8'h00);
    zeroB    = (expB == 8'h00);
    nanA     = (expA == 8'hFF) && (opA_q[FP_MAN_W-1:0] != '0);
    nanB     = (expB == 8'hFF) && (opB_q[FP_MAN_W-1:0] != '0);
    infA     = (expA == 8'hFF) && (opA_q[FP_MAN_W-1:0] == '0);
    infB     = (expB == 8'hFF) && (opB_q[FP_MAN_W-1:0] == '0);
    magA     = zeroA ? '0 : opA_q[30:0];
    magB     = zeroB ? '0 : opB_q[30:0];
    swap     = (magB > magA);
    bigMag   = swap ? magB : magA;
    smallMag = swap ? magA : magB;
    bigSign  = swap ? signB : signA;
    expDiff  = bigMag[30:23] - smallMag[30:23];
    shamt    = (expDiff > 8'd26) ? 5'd26 : expDiff[4:0];
    manBig   = {1'b1, bigMag[22:0], 3'b000};
    manSmall = (smallMag == '0) ? '0 : {1'b1, smallMag[22:0], 3'b000};
    shifted  = manSmall >> shamt;
    lostMask = ~({27{1'b1}} << shamt);
    manAligned = {shifted[26:1], shifted[0] | (|(manSmall & lostMask))};

    alignSpecial = 1'b1;
    alignSpecVal = '0;
    if (nanA || nanB) begin
      alignSpecVal = FP_QNAN;
    end else if (infA && infB && (signA != signB)) begin
      alignSpecVal = FP_QNAN;
    end else if (infA) begin
      alignSpecVal = {signA, FP_PINF[30:0]};
    end else if (infB) begin
      alignSpecVal = {signB, FP_PINF[30:0]};
    end else if (zeroA && zeroB) begin
      alignSpecVal = {signA & signB, 31'd0};
    end else begin
      alignSpecial = 1'b0;
    end
  end

  // Round-to-nearest-even on the G/R/S bits below the 24-bit mantissa.
  always_comb begin
    roundUp = manX_q[2] & (manX_q[1] | manX_q[0] | manX_q[3]);
    mantR   = {1'b0, manX_q[26:3]} + {24'd0, roundUp};
    expR    = exp_q + {9'd0, mantR[24]};
    if (special_q) begin
      roundResult = specVal_q;
    end else if (expR >= 10'd255) begin
      roundResult = {sign_q, FP_PINF[30:0]};
    end else if (mantR[24]) begin
      roundResult = {sign_q, expR[7:0], mantR[23:1]};
    end else begin
      roundResult = {sign_q, expR[7:0], mantR[22:0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    op0_d     = op0_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    sign_d    = sign_q;
    effSub_d  = effSub_q;
    exp_d     = exp_q;
    manX_d    = manX_q;
    manY_d    = manY_q;
    sum_d     = sum_q;
    special_d = special_q;
    specVal_d = specVal_q;
    out_d     = out_q;

    case (state_q)
      FPU_IDLE: begin
        if (isFpOpcode(instrIn.opcode)) begin
          state_d  = FPU_ALIGN;
          opcode_d = instrIn.opcode;
          op0_d    = instrIn.op0;
          opA_d    = instrIn.dat1;
          opB_d    = instrIn.dat2;
        end
      end
      FPU_ALIGN: begin
        state_d   = FPU_ADDSUB;
        sign_d    = bigSign;
        effSub_d  = signA ^ signB;
        exp_d     = {2'b00, bigMag[30:23]};
        manX_d    = manBig;
        manY_d    = manAligned;
        special_d = alignSpecial;
        specVal_d = alignSpecVal;
      end
      FPU_ADDSUB: begin
        state_d = FPU_NORM;
        sum_d   = effSub_q ? ({1'b0, manX_q} - {1'b0, manY_q})
                           : ({1'b0, manX_q} + {1'b0, manY_q});
      end
      FPU_NORM: begin
        state_d = FPU_ROUND;
        // A zero or underflowed result overrides the datapath, but never an earlier special.
        if (sum_q[27]) begin
          manX_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + 10'd1;
        end else if (sum_q[26:0] == '0) begin
          if (!special_q) begin
            special_d = 1'b1;
            specVal_d = '0;
          end
        end else begin
          manX_d = sum_q[26:0] << lzCount;
          exp_d  = exp_q - {5'd0, lzCount};
          if (!special_q && (exp_q <= {5'd0, lzCount})) begin
            special_d = 1'b1;
            specVal_d = {sign_q, 31'd0};
          end
        end
      end
      FPU_ROUND: begin
        state_d = FPU_DONE;
        out_d   = {opcode_q, op0_q, 32'd0, roundResult};
      end
      FPU_DONE: begin
        if (backpressure_write_back) begin
          state_d = FPU_IDLE;
          out_d   = NOP_INSTR;
        end
      end
      default: begin
        state_d = FPU_IDLE;
        out_d   = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FPU_IDLE;
      out_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Datapath registers are only consumed after being written by an accepted op.
  always_ff @(posedge clk) begin
    opcode_q  <= opcode_d;
    op0_q     <= op0_d;
    opA_q     <= opA_d;
    opB_q     <= opB_d;
    sign_q    <= sign_d;
    effSub_q  <= effSub_d;
    exp_q     <= exp_d;
    manX_q    <= manX_d;
    manY_q    <= manY_d;
    sum_q     <= sum_d;
    special_q <= special_d;
    specVal_q <= specVal_d;
  end

  assign instruction_out_floating_point = out_q;
  assign backpressure_exec_fpu          = (state_q == FPU_IDLE);

endmodule
